// File: rtl/fp_cmp_pkg.sv
// Shared encodings and field-offset helpers for the FloPoCo-format comparator.
package fp_cmp_pkg;

    // Exception field encodings (top two bits of every operand)
    localparam logic [1:0] EXN_ZERO = 2'b00;
    localparam logic [1:0] EXN_NORM = 2'b01;
    localparam logic [1:0] EXN_INF  = 2'b10;
    localparam logic [1:0] EXN_NAN  = 2'b11;

    // Relation select codes; 6 and 7 are reserved and always yield flag = 0
    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_LT = 3'd2;
    localparam logic [2:0] OP_LE = 3'd3;
    localparam logic [2:0] OP_GT = 3'd4;
    localparam logic [2:0] OP_GE = 3'd5;

    // Total operand width: exn(2) + sign(1) + exponent + fraction
    function automatic int fp_width(input int we, input int wf);
        return we + wf + 3;
    endfunction

    // Low bit of the two-bit exception field
    function automatic int exn_lo(input int we, input int wf);
        return we + wf + 1;
    endfunction

    // Sign bit position
    function automatic int sign_pos(input int we, input int wf);
        return we + wf;
    endfunction

    // Most significant exponent bit; the fraction occupies [wf-1:0] below it
    function automatic int exp_hi(input int we, input int wf);
        return we + wf - 1;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_core.sv
// Combinational FloPoCo comparator: magnitude-key ordering, NaN detection,
// min/max selection. No subtractor; a single key compare drives everything.
module fp_cmp_core
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 20
) (
    input  logic [WE+WF+2:0] a,
    input  logic [WE+WF+2:0] b,
    output logic             lt,
    output logic             eq,
    output logic             unordered,
    output logic [WE+WF+2:0] min,
    output logic [WE+WF+2:0] max
);

    localparam int EXN_L = exn_lo(WE, WF);
    localparam int SGN   = sign_pos(WE, WF);
    localparam int EXP_H = exp_hi(WE, WF);
    localparam int KW    = 2 + WE + WF;

    // Key = {rank, exp, frac}; zero and inf drop their payload bits
    function automatic logic [KW-1:0] mag_key(input logic [1:0] exn,
                                              input logic [WE+WF-1:0] body);
        case (exn)
            EXN_ZERO: return '0;
            EXN_NORM: return {2'b01, body};
            default:  return {2'b10, {(WE + WF){1'b0}}};
        endcase
    endfunction

    logic [1:0]    exn_a, exn_b;
    logic          sgn_a, sgn_b;
    logic          nan_a, nan_b, zero_both;
    logic [KW-1:0] key_a, key_b;

    assign exn_a     = a[EXN_L+1:EXN_L];
    assign exn_b     = b[EXN_L+1:EXN_L];
    assign sgn_a     = a[SGN];
    assign sgn_b     = b[SGN];
    assign nan_a     = (exn_a == EXN_NAN);
    assign nan_b     = (exn_b == EXN_NAN);
    assign zero_both = (exn_a == EXN_ZERO) && (exn_b == EXN_ZERO);
    assign key_a     = mag_key(exn_a, a[EXP_H:0]);
    assign key_b     = mag_key(exn_b, b[EXP_H:0]);

    // Signed ordering from magnitude keys; NaN forces every relation false
    always_comb begin
        unordered = nan_a || nan_b;
        eq = !unordered && (key_a == key_b) && ((sgn_a == sgn_b) || zero_both);
        if (unordered || zero_both)
            lt = 1'b0;
        else if (sgn_a != sgn_b)
            lt = sgn_a;
        else if (!sgn_a)
            lt = (key_a < key_b);
        else
            lt = (key_a > key_b);

        // Equal operands keep A as min and B as max, bit-exact
        if (nan_a && nan_b) begin
            min = a;
            max = a;
        end else if (nan_a) begin
            min = b;
            max = b;
        end else if (nan_b) begin
            min = a;
            max = a;
        end else if (lt || eq) begin
            min = a;
            max = b;
        end else begin
            min = b;
            max = a;
        end
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Pipelined FloPoCo comparator: stage 1 captures the compare result, stages
// 2..LAT are plain delay registers, all stages stall together on backpressure.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE   = 11,
    parameter int WF   = 20,
    parameter int LAT  = 2,
    parameter int TAGW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WE+WF+2:0]  in_a,
    input  logic [WE+WF+2:0]  in_b,
    input  logic [2:0]        op,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag,
    output logic              unordered,
    output logic [WE+WF+2:0]  min_out,
    output logic [WE+WF+2:0]  max_out,
    output logic [TAGW-1:0]   out_tag
);

    localparam int W = fp_width(WE, WF);

    logic         c_lt, c_eq, c_un, c_flag, en;
    logic [W-1:0] c_min, c_max;

    logic            v_q   [LAT];
    logic            f_q   [LAT];
    logic            u_q   [LAT];
    logic [W-1:0]    min_q [LAT];
    logic [W-1:0]    max_q [LAT];
    logic [TAGW-1:0] tag_q [LAT];

    fp_cmp_core #(
        .WE(WE),
        .WF(WF)
    ) u_core (
        .a        (in_a),
        .b        (in_b),
        .lt       (c_lt),
        .eq       (c_eq),
        .unordered(c_un),
        .min      (c_min),
        .max      (c_max)
    );

    // Map the selected relation onto the core's lt/eq/unordered results
    always_comb begin
        c_flag = 1'b0;
        case (op)
            OP_EQ:   c_flag = c_eq;
            OP_NE:   c_flag = !c_eq;
            OP_LT:   c_flag = c_lt;
            OP_LE:   c_flag = c_lt || c_eq;
            OP_GT:   c_flag = !(c_lt || c_eq || c_un);
            OP_GE:   c_flag = !(c_lt || c_un);
            default: c_flag = 1'b0;
        endcase
    end

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1 captures the compare; later stages shift; everything holds when !en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                v_q[i]   <= 1'b0;
                f_q[i]   <= 1'b0;
                u_q[i]   <= 1'b0;
                min_q[i] <= '0;
                max_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (en) begin
            v_q[0]   <= in_valid;
            f_q[0]   <= c_flag;
            u_q[0]   <= c_un;
            min_q[0] <= c_min;
            max_q[0] <= c_max;
            tag_q[0] <= in_tag;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_q[i]   <= v_q[i-1];
                f_q[i]   <= f_q[i-1];
                u_q[i]   <= u_q[i-1];
                min_q[i] <= min_q[i-1];
                max_q[i] <= max_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = v_q[LAT-1];
    assign flag      = f_q[LAT-1];
    assign unordered = u_q[LAT-1];
    assign min_out   = min_q[LAT-1];
    assign max_out   = max_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];

endmodule
